fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Instruction-fetch controller that sequences the instruction stream into the decoder. It owns the PC and drives a single-outstanding memory request/acknowledge handshake. It holds the fetched word in an instruction register presented to the decoder, honours pipeline stall and branch/jump redirects, flags unsupported opcodes, and counts retired fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  system clock, all state on rising edge
nRst  input  1  asynchronous active-low reset
mem_req  output  1  instruction-memory read request
mem_addr  output  32  word-aligned fetch address; stable while mem_req=1
mem_ack  input  1  memory completes request this cycle; mem_rdata valid
mem_rdata  input  32  fetched instruction word
stall  input  1  downstream not accepting the held instruction
redirect_valid  input  1  branch/jump taken; restart fetch at redirect_pc
redirect_pc  input  32  redirect target; bits [1:0] ignored, forced to 0
inst  output  32  instruction register, feeds decoder inst input
inst_pc  output  32  address of inst
inst_valid  output  1  inst holds a live instruction
inst_illegal  output  1  inst_valid=1 and opcode unsupported
fetch_count  output  32  number of instructions consumed downstream

Behaviour:
- Reset (nRst=0, async): state=BOOT, pc=RESET_PC, inst=0, inst_pc=0, inst_valid=0, mem_req=0, fetch_count=0, pending_pc=0.
- States:
  - BOOT: one cycle, no request; always goes to FETCH.
  - FETCH: mem_req=1, mem_addr=pc.
  - HOLD: inst_valid=1.
  - FLUSH: mem_req=1 and mem_addr=pc held; the returning data will be discarded.
- mem_req and mem_addr are registered outputs derived from state and pc. A request is never dropped or changed before mem_ack.
- FETCH:
  - mem_ack=1 and redirect_valid=0: inst<=mem_rdata, inst_pc<=pc, go HOLD.
  - mem_ack=1 and redirect_valid=1: discard data, pc<=redirect_pc, stay FETCH. mem_req stays high with the new address next cycle.
  - mem_ack=0 and redirect_valid=1: pending_pc<=redirect_pc, go FLUSH.
  - Otherwise: wait.
- FLUSH:
  - mem_ack=1: discard data, pc<=pending_pc, go FETCH. mem_req stays high with the new address next cycle.
  - redirect_valid=1 while waiting: pending_pc is overwritten; the latest redirect wins.
  - redirect_valid=1 together with mem_ack=1: pc<=redirect_pc.
- HOLD:
  - redirect_valid=1: highest priority. The held instruction is not consumed, fetch_count is unchanged, pc<=redirect_pc, inst_valid drops next cycle, go FETCH.
  - stall=0: instruction consumed this cycle. fetch_count+=1 (wraps 2^32-1 to 0), pc<=pc+4 (modulo 2^32, wraps FFFF_FFFC to 0), go FETCH.
  - stall=1: hold inst, inst_pc and inst_valid unchanged.
- Zero-wait memory timing:
  - Request at cycle N, ack at N, inst_valid at N+1.
  - Peak throughput is one instruction per 2 cycles.
- inst_illegal is combinational on the registered inst. It is 1 when inst_valid=1 and either inst[1:0]!=2'b11 or inst[6:0] is not in {0000011, 0010011, 0011011, 0110011, 0111011, 0100011, 1100011, 1101111, 0110111}. The sequencer does not block on illegal; downstream decides.
- mem_ack outside FETCH/FLUSH is ignored.
- Reset mid-request: mem_req drops immediately, with no handshake completion required; the memory side must tolerate abandonment.
- stall has no effect outside HOLD.

Decomposition:
- Shared package fetch_pkg:
  - state enum {BOOT, FETCH, HOLD, FLUSH}, 2 bits
  - opcode localparams for the supported set, which the decoder's type table also uses
  - INST_BYTES=4
- Single module; no sub-module needed. The opcode-legality check may be a package function.

Test Plan:
- Reset release, RESET_PC=0, ack same cycle as req, stall=0 -> mem_addr sequence 0, 4, 8; inst_valid pulses every other cycle; fetch_count=3 after third consume.
- Memory ack delayed 3 cycles with rdata=32'h00A00093 -> mem_req and mem_addr held 3 cycles; inst_valid=1 one cycle after ack; inst_illegal=0.
- HOLD with stall=1 for 5 cycles -> inst, inst_pc and inst_valid stable; no mem_req; fetch_count unchanged; release -> next mem_addr=inst_pc+4.
- redirect_valid with redirect_pc=32'h0000_0103 while in FETCH waiting for ack -> FLUSH; late ack data never reaches inst; next mem_addr=32'h0000_0100.
- Two redirects during FLUSH (0x200, then 0x300) -> fetch resumes at 0x300; redirect in HOLD simultaneous with stall=0 -> no count increment, next addr = redirect target.
- rdata=32'h0000_0007 -> inst_illegal=1. Assert nRst mid-FETCH -> mem_req=0 the same cycle; after release, first mem_addr=RESET_PC. pc=FFFF_FFFC consumed -> next addr 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the instruction-fetch sequencer and the
// decoder.
//   fetch_state_e       sequencer control states (2-bit encoding)
//   INST_BYTES          size of one instruction word in bytes (PC step)
//   OPC_*               major opcodes the core supports; the decoder's type
//                       table uses the same constants
//   opcode_supported()  legality test for a 7-bit major opcode field
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

  localparam int unsigned INST_BYTES = 4;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;

  // A word is legal only when it is a 32-bit encoding (low bits 11) and
  // its major opcode is one of the supported set.
  function automatic logic opcode_supported(input logic [6:0] opcode);
    logic known;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_OP, OPC_OP32,
      OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_LUI: known = 1'b1;
      default:                                 known = 1'b0;
    endcase
    return known && (opcode[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller.
// Owns the PC, issues single-outstanding read requests to instruction
// memory, captures the returned word into an instruction register for the
// decoder, honours downstream stall and branch/jump redirects, flags
// unsupported opcodes and counts instructions consumed downstream.
//
// Ports:
//   clk             system clock, all state on rising edge
//   nRst            asynchronous active-low reset
//   mem_req         instruction-memory read request (registered)
//   mem_addr        word-aligned fetch address, stable while mem_req=1
//   mem_ack         memory completes the request this cycle
//   mem_rdata       fetched instruction word, valid with mem_ack
//   stall           downstream not accepting the held instruction
//   redirect_valid  branch/jump taken, restart fetch at redirect_pc
//   redirect_pc     redirect target, low two bits forced to zero
//   inst            instruction register presented to the decoder
//   inst_pc         address of inst
//   inst_valid      inst holds a live instruction
//   inst_illegal    inst_valid=1 and the opcode is unsupported
//   fetch_count     number of instructions consumed downstream
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nRst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        inst_illegal,
  output logic [31:0] fetch_count
);

  // The reset PC is word-aligned by construction even if the parameter
  // is not.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] PC_STEP          = 32'(INST_BYTES);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pending_pc_q, pending_pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         inst_valid_q, inst_valid_d;
  logic         mem_req_q, mem_req_d;
  logic [31:0]  fetch_count_q, fetch_count_d;

  logic [31:0]  redirect_target;
  logic         redirect_pc_unused;

  // Redirect targets are always fetched word-aligned; the dropped bits
  // carry no information for the fetch path.
  assign redirect_target    = {redirect_pc[31:2], 2'b00};
  assign redirect_pc_unused = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC_ALIGNED;
      pending_pc_q  <= 32'h0000_0000;
      inst_q        <= 32'h0000_0000;
      inst_pc_q     <= 32'h0000_0000;
      inst_valid_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_pc_q  <= pending_pc_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      inst_valid_q  <= inst_valid_d;
      mem_req_q     <= mem_req_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_pc_d  = pending_pc_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (mem_ack) begin
          if (redirect_valid) begin
            // The returning word belongs to the wrong path; the new
            // request goes out immediately with the redirect address.
            pc_d = redirect_target;
          end else begin
            inst_d    = mem_rdata;
            inst_pc_d = pc_q;
            state_d   = HOLD;
          end
        end else if (redirect_valid) begin
          // The outstanding request cannot be withdrawn, so remember the
          // target and let FLUSH absorb the stale response.
          pending_pc_d = redirect_target;
          state_d      = FLUSH;
        end
      end

      FLUSH: begin
        if (mem_ack) begin
          pc_d    = redirect_valid ? redirect_target : pending_pc_q;
          state_d = FETCH;
        end else if (redirect_valid) begin
          pending_pc_d = redirect_target;
        end
      end

      HOLD: begin
        // A redirect kills the held instruction before it is consumed,
        // even when downstream is ready to take it.
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = FETCH;
        end else if (!stall) begin
          fetch_count_d = fetch_count_q + 32'd1;
          pc_d          = pc_q + PC_STEP;
          state_d       = FETCH;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase

    // Request and valid flags are registered from the next state so the
    // memory and decoder see clean flop outputs.
    mem_req_d    = (state_d == FETCH) || (state_d == FLUSH);
    inst_valid_d = (state_d == HOLD);
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = pc_q;
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;
  assign inst_valid   = inst_valid_q;
  assign fetch_count  = fetch_count_q;
  assign inst_illegal = inst_valid_q && !opcode_supported(inst_q[6:0]);

endmodule
